decode_stage: RTL and testbench
===============================

# decode_stage

Registered, handshaked RV32I/RV64I instruction decode stage. It sits between the fetch unit and the execute stage. Each accepted instruction word is turned into a control bundle: ALU op, jump/branch op, load/store controls, register addresses and enables, and a sign-extended immediate. The bundle is held behind a valid/ready interface with flush and illegal-instruction detection. Unlike a purely combinational decoder, it buffers, back-pressures, and flags every encoding it does not accept.

## Interface
- XLEN, 32: datapath width; legal values 32, 64 (64 enables LD/LWU/SD, 6-bit shamt)
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  fetch offers instruction
- in_ready  output  1  stage can accept
- in_instr  input  32  instruction word
- in_pc  input  XLEN  PC of in_instr
- flush  input  1  discard all held/incoming instructions
- out_valid  output  1  bundle valid
- out_ready  input  1  execute accepts bundle
- out_pc  output  XLEN  PC of bundle
- out_alu_op  output  4  ADD=0 SUB=1 SLT=2 SLTU=3 AND=4 OR=5 XOR=6 SLL=7 SRL=8 SRA=9 PASSB=10 (LUI)
- out_alu_en  output  1  ALU result used
- out_use_imm / out_use_pc  output  1 each  ALU B = imm / ALU A = pc (AUIPC, JAL)
- out_jbl_en  output  1  jump/branch instruction
- out_jbl_op  output  3  JAL=0 JALR=1 BEQ=2 BNE=3 BLT=4 BGE=5 BLTU=6 BGEU=7
- out_load / out_store  output  1 each  memory op
- out_ls_width  output  3  funct3 of load/store
- out_rs1 / out_rs2 / out_rd  output  5 each  register addresses, 0 when unused
- out_rs1_en / out_rs2_en / out_rd_we  output  1 each  read/write enables
- out_imm  output  XLEN  sign-extended immediate
- out_illegal  output  1  illegal encoding; all other controls 0
- out_ecall / out_ebreak  output  1 each  system instructions

## Operation
- Transfer in: in_valid && in_ready at rising edge. Transfer out: out_valid && out_ready.
- Decode is combinational on in_instr and is registered on acceptance.
- Immediates: I, S, B (bit0=0), U (imm[31:12]<<12), J (bit0=0); all sign-extended from bit 31 to XLEN.
- Opcodes are LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM.
  - FENCE decodes as NOP: valid, no enables.
  - XLEN=64 adds OP-IMM-32 and OP-32. These use the same alu_op; out_ls_width[2] is reused as a "word" flag.
- rd==0 forces out_rd_we=0. The out_rd field still carries 0.
- Illegal cases:
  - unknown opcode
  - instr[1:0]!=2'b11
  - BRANCH funct3 010/011
  - LOAD funct3 011/110 (XLEN=32), 111 (any)
  - STORE funct3 ≥ 011 (XLEN=32), ≥ 100 (64)
  - bad funct7 on OP, shifts, or SRAI/SRLI
  - shamt[5]=1 when XLEN=32
  - SYSTEM other than exact ECALL/EBREAK
- An illegal instruction still produces a bundle, with out_illegal=1 and out_pc valid for trap handling.
- flush: all held bundles are dropped. A transfer in on the same cycle is discarded. in_ready stays asserted.
- rst has priority over flush.

## Timing
- Reset values: out_valid=0, all out_* data/controls=0, in_ready=1 (first cycle after rst deasserts). No transfer occurs while rst=1.
- Latency is 1 cycle: an instruction accepted at edge N gives out_valid=1 after edge N.
- Throughput is 1 instruction/cycle with out_ready held high.
- out_* are stable while out_valid && !out_ready (no change until transfer).
- Flush asserted at edge N gives out_valid=0 after edge N.
- Simultaneous transfer out and transfer in (full pipeline) keeps out_valid=1, with the new bundle visible the next cycle.

## Configuration
- DECODE_SKID_BUFFER_EN defined:
  - Two-entry skid buffer. in_ready is a register output with no combinational path from out_ready.
  - When out_ready drops, one extra instruction is absorbed into the skid slot, and in_ready deasserts the following cycle.
  - Order is preserved: the skid entry drains before new input.
- Not defined:
  - Single output register.
  - in_ready = !out_valid || out_ready, combinational.
  - No extra storage.

## Test plan
- Reset, then stream ADDI x1,x0,-1 (0xFFF00093) at PC 0x100 → next cycle out_alu_op=0, out_use_imm=1, out_rs1=0, out_rd=1, out_rd_we=1, out_imm=0xFFFFFFFF, out_pc=0x100.
- BEQ 0xFE000EE3 → out_jbl_en=1, out_jbl_op=2, out_rs1_en=out_rs2_en=1, out_imm=-4, out_rd_we=0.
- Illegal 0x00000000 and LOAD funct3=111 → out_illegal=1, all enables 0, out_pc correct. XLEN=64: LD 0x0000B083 legal, out_ls_width=3.
- Back-pressure: stream 8 instructions, out_ready low for cycles 3–6 → all 8 exit in order, no duplication or loss. Skid build: in_ready falls exactly one cycle after out_ready falls.
- Flush with a full buffer and concurrent in_valid → out_valid=0 next cycle. None of the 3 instructions appear. The next instruction has 1-cycle latency.
- ADDI x0,x0,5 → out_rd_we=0. ECALL 0x00000073 → out_ecall=1. EBREAK 0x00100073 → out_ebreak=1. 0x00200073 → out_illegal=1.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked RV32I/RV64I instruction decode stage.
// Each accepted instruction word is decoded into a control bundle.
// The bundle is held behind a valid/ready output interface.
// Encodings that are not accepted produce a bundle with out_illegal=1 and
// out_pc intact, so that a trap can be raised downstream.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        fetch-side handshake
//   in_instr, in_pc          instruction word and its PC
//   flush                    drop every held bundle and any same-cycle input
//   out_valid/out_ready      execute-side handshake
//   out_*                    decoded control bundle (see field comments below)
//
// Optional build macro: DECODE_SKID_BUFFER_EN
//   defined     : two-entry skid buffer; in_ready is a flop, no comb path
//                 from out_ready
//   not defined : single output register; in_ready = !out_valid || out_ready
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_alu_op,
  output logic            out_alu_en,
  output logic            out_use_imm,
  output logic            out_use_pc,
  output logic            out_jbl_en,
  output logic [2:0]      out_jbl_op,
  output logic            out_load,
  output logic            out_store,
  output logic [2:0]      out_ls_width,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic            out_ecall,
  output logic            out_ebreak
);

  localparam bit IS64 = (XLEN == 64);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLT   = 4'd2;
  localparam logic [3:0] ALU_SLTU  = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] JBL_JAL  = 3'd0;
  localparam logic [2:0] JBL_JALR = 3'd1;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    logic            alu_en;
    logic            use_imm;
    logic            use_pc;
    logic            jbl_en;
    logic [2:0]      jbl_op;
    logic            load;
    logic            store;
    logic [2:0]      ls_width;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_we;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            ecall;
    logic            ebreak;
  } bundle_t;

  // funct3 to ALU op; alt selects SUB/SRA (instr[30])
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [4:0]      rd_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_s_s;
  logic [XLEN-1:0] imm_b_s;
  logic [XLEN-1:0] imm_u_s;
  logic [XLEN-1:0] imm_j_s;
  logic            illegal_s;
  bundle_t         dec_s;
  bundle_t         out_r;
  logic            out_valid_r;

  assign opcode_s = in_instr[6:0];
  assign funct3_s = in_instr[14:12];
  assign funct7_s = in_instr[31:25];
  assign rs1_s    = in_instr[19:15];
  assign rs2_s    = in_instr[24:20];
  assign rd_s     = in_instr[11:7];

  // Sign-extending casts from bit 31 to XLEN
  assign imm_i_s = XLEN'($signed(in_instr[31:20]));
  assign imm_s_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b_s = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u_s = XLEN'($signed({in_instr[31:12], 12'h000}));
  assign imm_j_s = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  // Combinational decode: fill fields per opcode, flag illegal, then clean up
  always_comb begin
    dec_s     = '0;
    illegal_s = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      illegal_s = 1'b1;
    end else begin
      case (opcode_s)
        OPC_LUI: begin
          dec_s.alu_en = 1'b1; dec_s.alu_op = ALU_PASSB; dec_s.use_imm = 1'b1;
          dec_s.rd_we = 1'b1; dec_s.rd = rd_s; dec_s.imm = imm_u_s;
        end
        OPC_AUIPC: begin
          dec_s.alu_en = 1'b1; dec_s.alu_op = ALU_ADD; dec_s.use_imm = 1'b1; dec_s.use_pc = 1'b1;
          dec_s.rd_we = 1'b1; dec_s.rd = rd_s; dec_s.imm = imm_u_s;
        end
        OPC_JAL: begin
          dec_s.jbl_en = 1'b1; dec_s.jbl_op = JBL_JAL;
          dec_s.alu_en = 1'b1; dec_s.alu_op = ALU_ADD; dec_s.use_imm = 1'b1; dec_s.use_pc = 1'b1;
          dec_s.rd_we = 1'b1; dec_s.rd = rd_s; dec_s.imm = imm_j_s;
        end
        OPC_JALR: begin
          dec_s.jbl_en = 1'b1; dec_s.jbl_op = JBL_JALR;
          dec_s.alu_en = 1'b1; dec_s.alu_op = ALU_ADD; dec_s.use_imm = 1'b1;
          dec_s.rs1_en = 1'b1; dec_s.rs1 = rs1_s;
          dec_s.rd_we = 1'b1; dec_s.rd = rd_s; dec_s.imm = imm_i_s;
          illegal_s = (funct3_s != 3'b000);
        end
        OPC_BRANCH: begin
          // 000/001 -> BEQ/BNE (2/3), 1xx -> BLT..BGEU (4..7)
          dec_s.jbl_en = 1'b1;
          dec_s.jbl_op = funct3_s[2] ? {1'b1, funct3_s[1:0]} : {2'b01, funct3_s[0]};
          dec_s.rs1_en = 1'b1; dec_s.rs1 = rs1_s; dec_s.rs2_en = 1'b1; dec_s.rs2 = rs2_s;
          dec_s.imm = imm_b_s;
          illegal_s = (funct3_s[2:1] == 2'b01);
        end
        OPC_LOAD: begin
          dec_s.load = 1'b1; dec_s.ls_width = funct3_s;
          dec_s.alu_en = 1'b1; dec_s.alu_op = ALU_ADD; dec_s.use_imm = 1'b1;
          dec_s.rs1_en = 1'b1; dec_s.rs1 = rs1_s;
          dec_s.rd_we = 1'b1; dec_s.rd = rd_s; dec_s.imm = imm_i_s;
          case (funct3_s)
            3'b011, 3'b110: illegal_s = !IS64;
            3'b111:         illegal_s = 1'b1;
            default:        illegal_s = 1'b0;
          endcase
        end
        OPC_STORE: begin
          dec_s.store = 1'b1; dec_s.ls_width = funct3_s;
          dec_s.alu_en = 1'b1; dec_s.alu_op = ALU_ADD; dec_s.use_imm = 1'b1;
          dec_s.rs1_en = 1'b1; dec_s.rs1 = rs1_s; dec_s.rs2_en = 1'b1; dec_s.rs2 = rs2_s;
          dec_s.imm = imm_s_s;
          illegal_s = IS64 ? funct3_s[2] : (funct3_s >= 3'b011);
        end
        OPC_OP_IMM, OPC_OP_IMM32: begin
          dec_s.alu_en = 1'b1; dec_s.use_imm = 1'b1;
          dec_s.alu_op = alu_from_f3(funct3_s, (funct3_s == 3'b101) && in_instr[30]);
          dec_s.rs1_en = 1'b1; dec_s.rs1 = rs1_s;
          dec_s.rd_we = 1'b1; dec_s.rd = rd_s; dec_s.imm = imm_i_s;
          if (opcode_s == OPC_OP_IMM32) begin
            // Word forms: 5-bit shamt, ls_width[2] marks the word result
            dec_s.ls_width = 3'b100;
            case (funct3_s)
              3'b000:  illegal_s = !IS64;
              3'b001:  illegal_s = !IS64 || (funct7_s != F7_ZERO);
              3'b101:  illegal_s = !IS64 || !((funct7_s == F7_ZERO) || (funct7_s == F7_ALT));
              default: illegal_s = 1'b1;
            endcase
          end else begin
            // RV64 shamt is 6 bits (funct6 check); on RV32 instr[25] must be 0
            case (funct3_s)
              3'b001:  illegal_s = IS64 ? (in_instr[31:26] != 6'b000000) : (funct7_s != F7_ZERO);
              3'b101:  illegal_s = IS64 ? !((in_instr[31:26] == 6'b000000) || (in_instr[31:26] == 6'b010000))
                                         : !((funct7_s == F7_ZERO) || (funct7_s == F7_ALT));
              default: illegal_s = 1'b0;
            endcase
          end
        end
        OPC_OP, OPC_OP32: begin
          dec_s.alu_en = 1'b1; dec_s.alu_op = alu_from_f3(funct3_s, in_instr[30]);
          dec_s.rs1_en = 1'b1; dec_s.rs1 = rs1_s; dec_s.rs2_en = 1'b1; dec_s.rs2 = rs2_s;
          dec_s.rd_we = 1'b1; dec_s.rd = rd_s;
          if (opcode_s == OPC_OP32) begin
            dec_s.ls_width = 3'b100;
            illegal_s = !IS64 ||
                        !((((funct3_s == 3'b000) || (funct3_s == 3'b101)) &&
                           ((funct7_s == F7_ZERO) || (funct7_s == F7_ALT))) ||
                          ((funct3_s == 3'b001) && (funct7_s == F7_ZERO)));
          end else begin
            // funct7=0100000 only exists for SUB and SRA
            illegal_s = !((funct7_s == F7_ZERO) ||
                          ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
          end
        end
        OPC_FENCE: begin
          illegal_s = 1'b0;
        end
        OPC_SYSTEM: begin
          if (in_instr == 32'h0000_0073) begin
            dec_s.ecall = 1'b1;
          end else if (in_instr == 32'h0010_0073) begin
            dec_s.ebreak = 1'b1;
          end else begin
            illegal_s = 1'b1;
          end
        end
        default: illegal_s = 1'b1;
      endcase
    end
    if (illegal_s) begin
      dec_s         = '0;
      dec_s.illegal = 1'b1;
    end else begin
      dec_s.rd_we = dec_s.rd_we && (dec_s.rd != 5'd0);
    end
    dec_s.pc = in_pc;
  end

`ifdef DECODE_SKID_BUFFER_EN
  bundle_t skid_r;
  logic    skid_valid_r;
  logic    in_ready_r;
  logic    accept_s;
  logic    out_free_s;

  assign in_ready   = in_ready_r;
  assign accept_s   = in_valid && in_ready_r;
  assign out_free_s = !out_valid_r || out_ready;

  // Output slot plus skid slot; in_ready_r tracks skid slot emptiness
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r        <= '0;
      out_valid_r  <= 1'b0;
      skid_r       <= '0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else if (out_free_s) begin
      // in_ready_r is low while the skid slot is full, so no accept here
      if (skid_valid_r) begin
        out_r        <= skid_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
        in_ready_r   <= 1'b1;
      end else if (accept_s) begin
        out_r       <= dec_s;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
      in_ready_r   <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid_r || out_ready;

  // Single output register: load on accept, clear valid when drained
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_r       <= dec_s;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end
`endif

  assign out_valid    = out_valid_r;
  assign out_pc       = out_r.pc;
  assign out_alu_op   = out_r.alu_op;
  assign out_alu_en   = out_r.alu_en;
  assign out_use_imm  = out_r.use_imm;
  assign out_use_pc   = out_r.use_pc;
  assign out_jbl_en   = out_r.jbl_en;
  assign out_jbl_op   = out_r.jbl_op;
  assign out_load     = out_r.load;
  assign out_store    = out_r.store;
  assign out_ls_width = out_r.ls_width;
  assign out_rs1      = out_r.rs1;
  assign out_rs2      = out_r.rs2;
  assign out_rd       = out_r.rd;
  assign out_rs1_en   = out_r.rs1_en;
  assign out_rs2_en   = out_r.rs2_en;
  assign out_rd_we    = out_r.rd_we;
  assign out_imm      = out_r.imm;
  assign out_illegal  = out_r.illegal;
  assign out_ecall    = out_r.ecall;
  assign out_ebreak   = out_r.ebreak;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (XLEN=32).
module tb_decode_stage;
  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      out_alu_op;
  logic            out_alu_en;
  logic            out_use_imm;
  logic            out_use_pc;
  logic            out_jbl_en;
  logic [2:0]      out_jbl_op;
  logic            out_load;
  logic            out_store;
  logic [2:0]      out_ls_width;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rs1_en;
  logic            out_rs2_en;
  logic            out_rd_we;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
  logic            out_ecall;
  logic            out_ebreak;

  int total;
  int bad;

  decode_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_op(out_alu_op), .out_alu_en(out_alu_en), .out_use_imm(out_use_imm),
    .out_use_pc(out_use_pc), .out_jbl_en(out_jbl_en), .out_jbl_op(out_jbl_op),
    .out_load(out_load), .out_store(out_store), .out_ls_width(out_ls_width),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_we(out_rd_we),
    .out_imm(out_imm), .out_illegal(out_illegal), .out_ecall(out_ecall),
    .out_ebreak(out_ebreak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] addi_enc(input int rd, input int imm);
    logic [11:0] i12;
    logic [4:0]  r5;
    i12 = 12'(imm);
    r5  = 5'(rd);
    return {i12, 5'd0, 3'b000, r5, 7'b0010011};
  endfunction

  // Offer one instruction for one cycle, return at the negedge after acceptance
  task automatic drive_one(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; out_ready = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 32'h0000_0100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if ({out_pc, out_imm, out_alu_op, out_rd, out_rd_we, out_illegal} !== '0) begin
      bad++; $display("FAIL reset_bundle got pc=%0h imm=%0h op=%0d rd=%0d we=%0b ill=%0b want all 0",
                      out_pc, out_imm, out_alu_op, out_rd, out_rd_we, out_illegal);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_addi;
    drive_one(32'hFFF0_0093, 32'h0000_0100);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0b want=1", out_valid); end
    total++; if (out_alu_op !== 4'd0 || out_alu_en !== 1'b1 || out_use_imm !== 1'b1 || out_use_pc !== 1'b0) begin
      bad++; $display("FAIL addi_alu got op=%0d en=%0b imm=%0b pc=%0b want 0/1/1/0", out_alu_op, out_alu_en, out_use_imm, out_use_pc);
    end
    total++; if (out_rs1 !== 5'd0 || out_rs1_en !== 1'b1 || out_rd !== 5'd1 || out_rd_we !== 1'b1) begin
      bad++; $display("FAIL addi_regs got rs1=%0d en=%0b rd=%0d we=%0b want 0/1/1/1", out_rs1, out_rs1_en, out_rd, out_rd_we);
    end
    total++; if (out_imm !== 32'hFFFF_FFFF) begin bad++; $display("FAIL addi_imm got=%0h want=ffffffff", out_imm); end
    total++; if (out_pc !== 32'h0000_0100) begin bad++; $display("FAIL addi_pc got=%0h want=100", out_pc); end
  endtask

  task automatic test_beq;
    drive_one(32'hFE00_0EE3, 32'h0000_0104);
    total++; if (out_jbl_en !== 1'b1 || out_jbl_op !== 3'd2) begin
      bad++; $display("FAIL beq_jbl got en=%0b op=%0d want 1/2", out_jbl_en, out_jbl_op);
    end
    total++; if (out_rs1_en !== 1'b1 || out_rs2_en !== 1'b1 || out_rd_we !== 1'b0) begin
      bad++; $display("FAIL beq_en got rs1=%0b rs2=%0b we=%0b want 1/1/0", out_rs1_en, out_rs2_en, out_rd_we);
    end
    total++; if (out_imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL beq_imm got=%0h want=fffffffc", out_imm); end
  endtask

  task automatic test_illegal;
    logic [31:0] tab [0:6];
    logic [XLEN-1:0] pc;
    // zero word, LOAD f3=111, LD (RV32), SD (RV32), OP funct7=1, SLLI shamt 32, bits[1:0]=10
    tab = '{32'h0000_0000, 32'h0000_7083, 32'h0000_B083, 32'h0010_B023,
            32'h0220_8133, 32'h0200_9093, 32'h0000_0092};
    for (int i = 0; i < 7; i++) begin
      pc = 32'h0000_0200 + 32'(4 * i);
      drive_one(tab[i], pc);
      total++;
      if ({out_valid, out_illegal, out_rd_we, out_rs1_en, out_rs2_en, out_alu_en, out_load, out_store, out_jbl_en} !== 9'b110000000
          || out_rd !== 5'd0 || out_pc !== pc) begin
        bad++; $display("FAIL illegal_%0d instr=%h got v=%0b ill=%0b we=%0b rs1en=%0b alu=%0b ld=%0b st=%0b pc=%0h want ill only pc=%0h",
                        i, tab[i], out_valid, out_illegal, out_rd_we, out_rs1_en, out_alu_en, out_load, out_store, out_pc, pc);
      end
    end
  endtask

  task automatic test_alu;
    drive_one(32'h4020_8133, 32'h0000_0300);   // sub x2,x1,x2
    total++; if (out_alu_op !== 4'd1 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_rd !== 5'd2 || out_rs2_en !== 1'b1 || out_use_imm !== 1'b0) begin
      bad++; $display("FAIL sub got op=%0d rs1=%0d rs2=%0d rd=%0d rs2en=%0b useimm=%0b want 1/1/2/2/1/0", out_alu_op, out_rs1, out_rs2, out_rd, out_rs2_en, out_use_imm);
    end
    drive_one(32'h1234_50B7, 32'h0000_0304);   // lui x1,0x12345
    total++; if (out_alu_op !== 4'd10 || out_imm !== 32'h1234_5000 || out_rd !== 5'd1 || out_rs1_en !== 1'b0) begin
      bad++; $display("FAIL lui got op=%0d imm=%0h rd=%0d rs1en=%0b want 10/12345000/1/0", out_alu_op, out_imm, out_rd, out_rs1_en);
    end
    drive_one(32'h4030_D093, 32'h0000_0308);   // srai x1,x1,3
    total++; if (out_alu_op !== 4'd9 || out_illegal !== 1'b0 || out_rd !== 5'd1) begin
      bad++; $display("FAIL srai got op=%0d ill=%0b rd=%0d want 9/0/1", out_alu_op, out_illegal, out_rd);
    end
    drive_one(32'h0000_A083, 32'h0000_030C);   // lw x1,0(x1)
    total++; if (out_load !== 1'b1 || out_ls_width !== 3'd2 || out_rd_we !== 1'b1 || out_illegal !== 1'b0) begin
      bad++; $display("FAIL lw got load=%0b w=%0d we=%0b ill=%0b want 1/2/1/0", out_load, out_ls_width, out_rd_we, out_illegal);
    end
  endtask

  task automatic test_system;
    drive_one(32'h0050_0013, 32'h0000_0400);   // addi x0,x0,5
    total++; if (out_rd_we !== 1'b0 || out_rd !== 5'd0 || out_imm !== 32'd5) begin
      bad++; $display("FAIL addi_x0 got we=%0b rd=%0d imm=%0h want 0/0/5", out_rd_we, out_rd, out_imm);
    end
    drive_one(32'h0000_0073, 32'h0000_0404);
    total++; if (out_ecall !== 1'b1 || out_ebreak !== 1'b0 || out_illegal !== 1'b0) begin
      bad++; $display("FAIL ecall got ecall=%0b ebreak=%0b ill=%0b want 1/0/0", out_ecall, out_ebreak, out_illegal);
    end
    drive_one(32'h0010_0073, 32'h0000_0408);
    total++; if (out_ebreak !== 1'b1 || out_ecall !== 1'b0 || out_illegal !== 1'b0) begin
      bad++; $display("FAIL ebreak got ebreak=%0b ecall=%0b ill=%0b want 1/0/0", out_ebreak, out_ecall, out_illegal);
    end
    drive_one(32'h0020_0073, 32'h0000_040C);
    total++; if (out_illegal !== 1'b1 || out_ecall !== 1'b0 || out_ebreak !== 1'b0 || out_pc !== 32'h0000_040C) begin
      bad++; $display("FAIL sys_bad got ill=%0b ecall=%0b ebreak=%0b pc=%0h want 1/0/0/40c", out_illegal, out_ecall, out_ebreak, out_pc);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 4) begin
        in_valid = 1'b1; in_instr = addi_enc(c + 1, c + 1); in_pc = 32'h0000_2000 + 32'(4 * c);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 1) begin
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0000_2000 + 32'(4 * (c - 1))) begin
          bad++; $display("FAIL b2b_%0d got v=%0b pc=%0h want v=1 pc=%0h", c, out_valid, out_pc, 32'h0000_2000 + 32'(4 * (c - 1)));
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [XLEN-1:0] got_pc [$];
    logic [XLEN-1:0] got_imm [$];
    logic            rdy_hist [0:15];
    logic [XLEN-1:0] held_pc;
    int              idx;
    idx = 0;
    held_pc = '0;
    for (int c = 0; c < 40 && got_pc.size() < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 6);
      if (idx < 8) begin
        in_valid = 1'b1; in_instr = addi_enc(idx + 1, idx + 1); in_pc = 32'h0000_1000 + 32'(4 * idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 16) rdy_hist[c] = in_ready;
      if (c == 3) held_pc = out_pc;
      if (c >= 4 && c <= 6) begin
        total++;
        if (out_valid !== 1'b1 || out_pc !== held_pc) begin
          bad++; $display("FAIL bp_hold_%0d got v=%0b pc=%0h want v=1 pc=%0h", c, out_valid, out_pc, held_pc);
        end
      end
      if (out_valid && out_ready) begin got_pc.push_back(out_pc); got_imm.push_back(out_imm); end
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got_pc.size() != 8) begin bad++; $display("FAIL bp_count got=%0d want=8", got_pc.size()); end
    for (int k = 0; k < got_pc.size(); k++) begin
      total++;
      if (got_pc[k] !== 32'h0000_1000 + 32'(4 * k) || got_imm[k] !== 32'(k + 1)) begin
        bad++; $display("FAIL bp_order_%0d got pc=%0h imm=%0h want pc=%0h imm=%0h", k, got_pc[k], got_imm[k], 32'h0000_1000 + 32'(4 * k), k + 1);
      end
    end
`ifdef DECODE_SKID_BUFFER_EN
    total++; if (rdy_hist[3] !== 1'b1 || rdy_hist[4] !== 1'b0) begin
      bad++; $display("FAIL bp_in_ready got c3=%0b c4=%0b want 1/0", rdy_hist[3], rdy_hist[4]);
    end
`else
    total++; if (rdy_hist[2] !== 1'b1 || rdy_hist[3] !== 1'b0) begin
      bad++; $display("FAIL bp_in_ready got c2=%0b c3=%0b want 1/0", rdy_hist[2], rdy_hist[3]);
    end
`endif
  endtask

  task automatic test_flush;
    int   k;
    logic seen;
    k = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = addi_enc(k + 1, 7); in_pc = 32'h0000_3000 + 32'(4 * k);
      #1;
      if (in_ready) k++;
      else break;
    end
`ifdef DECODE_SKID_BUFFER_EN
    total++; if (k != 2) begin bad++; $display("FAIL flush_fill got=%0d want=2", k); end
`else
    total++; if (k != 1) begin bad++; $display("FAIL flush_fill got=%0d want=1", k); end
`endif
    // Buffer full: flush together with a concurrent input
    flush = 1'b1; in_valid = 1'b1; in_instr = addi_enc(9, 9); in_pc = 32'h0000_3F00;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b want=1", in_ready); end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_leak got=%0b want=0", seen); end
    drive_one(addi_enc(3, 3), 32'h0000_4000);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_4000) begin
      bad++; $display("FAIL flush_next got v=%0b pc=%0h want v=1 pc=4000", out_valid, out_pc);
    end
    // Flush with an accepted-looking input on the same edge
    @(negedge clk);
    in_valid = 1'b1; in_instr = addi_enc(4, 4); in_pc = 32'h0000_5000; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_concurrent got=%0b want=0", out_valid); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0000_0000; in_pc = '0;
    test_reset();
    test_addi();
    test_beq();
    test_illegal();
    test_alu();
    test_system();
    test_back_to_back();
    test_backpressure();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
